// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel prescaled PWM with double-buffered duty updates
//
// Purpose: one shared prescaled counter (edge- or center-aligned) drives CHANNELS
// PWM comparators. Each channel's duty is the top RES bits of its DDS sample. The sample is
// captured into a staging register on load and moved to the active duty only at a period
// boundary, so the outputs never glitch mid-period.
//
// Ports:
//   clk           system clock, all logic on posedge
//   rst           synchronous active-high reset
//   en            1 = run, 0 = counter and outputs held idle
//   mode          requested alignment: 0 = edge, 1 = center (applied at a boundary)
//   prescale      counter advances once every prescale+1 clocks
//   modu          packed samples, channel k = modu[k*M +: M]
//   load          capture modu into the staging registers
//   wave          registered PWM outputs, one per channel
//   period_start  1-clk pulse coincident with the counter entering 0

module pwm_multi #(
    parameter int CHANNELS   = 4,
    parameter int M          = 12,
    parameter int RES        = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [CHANNELS*M-1:0] modu,
    input  logic                  load,
    output logic [CHANNELS-1:0]   wave,
    output logic                  period_start
);
    localparam logic [RES-1:0]        CNT_MAX = {RES{1'b1}};
    localparam logic [RES-1:0]        CNT_ONE = RES'(1);
    localparam logic [PRESCALE_W-1:0] PRE_ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [RES-1:0]        cnt_q, cnt_d;
    logic                  dir_down_q, dir_down_d;
    logic                  mode_q;
    logic                  en_q;
    logic [CHANNELS-1:0]   wave_q, wave_d;
    logic                  period_start_q, period_start_d;
    logic [RES-1:0]        staging_q [CHANNELS];
    logic [RES-1:0]        duty_q    [CHANNELS];

    logic tick;
    logic start;
    logic boundary;
    logic update;

    // Only the top RES bits of each sample matter.
    logic unused_modu;
    assign unused_modu = ^modu;

    always_comb begin
        tick  = en && (pre_cnt_q >= prescale);
        // The first enabled clock behaves like a boundary: the counter is
        // already parked at 0, so the new period starts here.
        start = en && !en_q;

        if (mode_q) begin
            boundary = tick && dir_down_q && (cnt_q == CNT_ONE);
        end else begin
            boundary = tick && (cnt_q == CNT_MAX);
        end

        // While idle the staging values track straight into the active set.
        update = boundary || start || !en;

        pre_cnt_d  = pre_cnt_q;
        cnt_d      = cnt_q;
        dir_down_d = dir_down_q;

        if (!en || start) begin
            pre_cnt_d  = '0;
            cnt_d      = '0;
            dir_down_d = 1'b0;
        end else if (tick) begin
            pre_cnt_d = '0;
            if (boundary) begin
                cnt_d      = '0;
                dir_down_d = 1'b0;
            end else if (mode_q && dir_down_q) begin
                cnt_d = cnt_q - CNT_ONE;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
                if (mode_q && (cnt_d == CNT_MAX)) begin
                    dir_down_d = 1'b1;
                end
            end
        end else begin
            pre_cnt_d = pre_cnt_q + PRE_ONE;
        end

        period_start_d = start || boundary;

        wave_d = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            wave_d[k] = en && (cnt_q <= duty_q[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_q      <= '0;
            cnt_q          <= '0;
            dir_down_q     <= 1'b0;
            mode_q         <= 1'b0;
            en_q           <= 1'b0;
            wave_q         <= '0;
            period_start_q <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                staging_q[k] <= '0;
                duty_q[k]    <= '0;
            end
        end else begin
            pre_cnt_q      <= pre_cnt_d;
            cnt_q          <= cnt_d;
            dir_down_q     <= dir_down_d;
            en_q           <= en;
            wave_q         <= wave_d;
            period_start_q <= period_start_d;
            // duty takes the pre-load staging value when load and a boundary coincide.
            for (int k = 0; k < CHANNELS; k++) begin
                if (load) begin
                    staging_q[k] <= modu[k*M + M - 1 -: RES];
                end
                if (update) begin
                    duty_q[k] <= staging_q[k];
                end
            end
            if (update) begin
                mode_q <= mode;
            end
        end
    end

    assign wave         = wave_q;
    assign period_start = period_start_q;

endmodule
